// File: rtl/mmio_arb_pkg.sv
// Shared types and default widths for the two-requester mapped-register bus arbiter.
package mmio_arb_pkg;

  localparam int unsigned DefAddrW       = 14;
  localparam int unsigned DefDataW       = 16;
  localparam int unsigned DefStarveLimit = 4;
  localparam int unsigned StarveCntW     = 4;

  typedef enum logic [1:0] {StIdle, StXfer, StAck} arb_state_e;
  typedef enum logic [1:0] {OwnNone, OwnCore, OwnDbg} arb_owner_e;

endpackage

// File: rtl/mmio_arb_starve_ctr.sv
// Saturating count of consecutive debug grants that the core lost; clear wins over hold and inc.
module mmio_arb_starve_ctr
  import mmio_arb_pkg::*;
#(
  parameter int unsigned Limit = DefStarveLimit
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic clr_i,
  input  logic hold_i,
  output logic at_limit_o
);

  logic [StarveCntW-1:0] cnt_q, cnt_d;

  assign at_limit_o = (cnt_q == StarveCntW'(Limit));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !hold_i && !at_limit_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mmio_bus_arbiter.sv
// Debug-priority arbiter for the mapped-register bus, one strobe per transfer, IDLE->XFER->ACK.
// Optional debug bus lock enabled by defining MMIO_ARB_LOCK_EN.
module mmio_bus_arbiter
  import mmio_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = DefAddrW,
  parameter int unsigned DATA_W       = DefDataW,
  parameter int unsigned STARVE_LIMIT = DefStarveLimit
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_coreReq,
  input  logic [ADDR_W-1:0] i_coreAddr,
  input  logic              i_coreWrEn,
  input  logic [DATA_W-1:0] i_coreData,
  output logic              o_coreAck,
  output logic [DATA_W-1:0] o_coreData,
  input  logic              i_dbgReq,
  input  logic [ADDR_W-1:0] i_dbgAddr,
  input  logic              i_dbgWrEn,
  input  logic [DATA_W-1:0] i_dbgData,
  output logic              o_dbgAck,
  output logic [DATA_W-1:0] o_dbgData,
`ifdef MMIO_ARB_LOCK_EN
  input  logic              i_dbgLock,
`endif
  output logic [ADDR_W-1:0] o_memAddr,
  output logic [DATA_W-1:0] o_memDataIn,
  output logic              o_memWrEn,
  output logic              o_memRdEn,
  input  logic [DATA_W-1:0] i_memDataOut,
  output logic              o_busy
);

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              wr_q, wr_d;

  logic dbg_win, core_win, lock_act, at_limit;
  logic starve_inc, starve_clr;

`ifdef MMIO_ARB_LOCK_EN
  assign lock_act = i_dbgLock && i_dbgReq;
`else
  assign lock_act = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_d     = wr_q;
    rdata_d  = rdata_q;
    dbg_win  = 1'b0;
    core_win = 1'b0;
    case (state_q)
      StIdle: begin
        dbg_win  = i_dbgReq && (!i_coreReq || lock_act || !at_limit);
        core_win = i_coreReq && !dbg_win;
        if (dbg_win) begin
          owner_d = OwnDbg;
          addr_d  = i_dbgAddr;
          wdata_d = i_dbgData;
          wr_d    = i_dbgWrEn;
          state_d = StXfer;
        end else if (core_win) begin
          owner_d = OwnCore;
          addr_d  = i_coreAddr;
          wdata_d = i_coreData;
          wr_d    = i_coreWrEn;
          state_d = StXfer;
        end
      end
      StXfer: begin
        // Writes return zero so the ack data is never stale.
        rdata_d = wr_q ? '0 : i_memDataOut;
        state_d = StAck;
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Counter only moves in IDLE: dbg_win/core_win are zero elsewhere.
  assign starve_inc = dbg_win && i_coreReq && !lock_act;
  assign starve_clr = (state_q == StIdle) && (core_win || !i_coreReq);

  mmio_arb_starve_ctr #(
    .Limit(STARVE_LIMIT)
  ) u_starve_ctr (
    .clk_i     (i_clk),
    .rst_i     (i_rst),
    .inc_i     (starve_inc),
    .clr_i     (starve_clr),
    .hold_i    (lock_act),
    .at_limit_o(at_limit)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      owner_q <= OwnNone;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
    end
  end

  assign o_memAddr   = addr_q;
  assign o_memDataIn = wdata_q;
  assign o_memWrEn   = (state_q == StXfer) && wr_q;
  assign o_memRdEn   = (state_q == StXfer) && !wr_q;
  assign o_coreAck   = (state_q == StAck) && (owner_q == OwnCore);
  assign o_dbgAck    = (state_q == StAck) && (owner_q == OwnDbg);
  assign o_coreData  = o_coreAck ? rdata_q : '0;
  assign o_dbgData   = o_dbgAck ? rdata_q : '0;
  assign o_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Directed self-checking bench for mmio_bus_arbiter (STARVE_LIMIT=4), optional MMIO_ARB_LOCK_EN.
module tb_mmio_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_wr, dbg_req, dbg_wr;
  logic [13:0] core_addr, dbg_addr;
  logic [15:0] core_wdata, dbg_wdata, mem_rdata;
  logic        core_ack, dbg_ack, mem_wr, mem_rd, busy;
  logic [15:0] core_rdata, dbg_rdata, mem_din;
  logic [13:0] mem_addr;
`ifdef MMIO_ARB_LOCK_EN
  logic        dbg_lock;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmio_bus_arbiter #(
    .ADDR_W      (14),
    .DATA_W      (16),
    .STARVE_LIMIT(4)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_coreReq   (core_req),
    .i_coreAddr  (core_addr),
    .i_coreWrEn  (core_wr),
    .i_coreData  (core_wdata),
    .o_coreAck   (core_ack),
    .o_coreData  (core_rdata),
    .i_dbgReq    (dbg_req),
    .i_dbgAddr   (dbg_addr),
    .i_dbgWrEn   (dbg_wr),
    .i_dbgData   (dbg_wdata),
    .o_dbgAck    (dbg_ack),
    .o_dbgData   (dbg_rdata),
`ifdef MMIO_ARB_LOCK_EN
    .i_dbgLock   (dbg_lock),
`endif
    .o_memAddr   (mem_addr),
    .o_memDataIn (mem_din),
    .o_memWrEn   (mem_wr),
    .o_memRdEn   (mem_rd),
    .i_memDataOut(mem_rdata),
    .o_busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int          dbg_cyc, core_cyc, ng, both, nacks, ndbg, ncore, ordinal, first_core;
  logic [9:0]  gpat;

  initial begin
    rst = 1'b1; core_req = 0; core_wr = 0; dbg_req = 0; dbg_wr = 0;
    core_addr = '0; dbg_addr = '0; core_wdata = '0; dbg_wdata = '0; mem_rdata = '0;
`ifdef MMIO_ARB_LOCK_EN
    dbg_lock = 1'b0;
`endif
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {mem_wr, mem_rd}, 0);
    chk("rst_acks", {core_ack, dbg_ack}, 0);
    chk("rst_bus", {mem_addr, mem_din}, 0);
    chk("rst_rdata", {core_rdata, dbg_rdata}, 0);
    tick();
    rst = 1'b0;

    // 1: core read alone
    core_req = 1; core_wr = 0; core_addr = 14'h0021; mem_rdata = 16'hBEEF;
    tick();
    chk("t1_xfer_rd", {mem_rd, mem_wr}, 2'b10);
    chk("t1_xfer_addr", mem_addr, 14'h0021);
    chk("t1_xfer_noack", core_ack, 0);
    tick();
    chk("t1_ack", core_ack, 1);
    chk("t1_ack_data", core_rdata, 16'hBEEF);
    chk("t1_ack_nostrobe", {mem_rd, mem_wr}, 0);
    core_req = 0;
    tick();
    chk("t1_idle", {busy, core_ack}, 0);
    chk("t1_addr_hold", mem_addr, 14'h0021);

    // 2: debug write, req dropped during XFER
    dbg_req = 1; dbg_wr = 1; dbg_addr = 14'h0008; dbg_wdata = 16'h00A5; mem_rdata = 16'h5555;
    tick();
    chk("t2_xfer_wr", {mem_wr, mem_rd}, 2'b10);
    chk("t2_xfer_bus", {mem_addr, mem_din}, {14'h0008, 16'h00A5});
    dbg_req = 0;
    tick();
    chk("t2_ack", dbg_ack, 1);
    chk("t2_ack_data", dbg_rdata, 0);
    chk("t2_ack_nostrobe", {mem_wr, mem_rd}, 0);
    tick();
    chk("t2_idle", {busy, dbg_ack, mem_wr}, 0);

    // 3: both assert together for one transfer each
    core_req = 1; core_wr = 0; core_addr = 14'h0030;
    dbg_req = 1; dbg_wr = 0; dbg_addr = 14'h0040; mem_rdata = 16'h1234;
    dbg_cyc = 99; core_cyc = 99;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (dbg_ack) begin
        dbg_cyc = c;
        chk("t3_dbg_data", dbg_rdata, 16'h1234);
        dbg_req = 0;
      end
      if (core_ack) begin
        core_cyc = c;
        core_req = 0;
      end
      if (c == 4) chk("t3_core_addr", mem_addr, 14'h0030);
    end
    chk("t3_dbg_ack_cyc", dbg_cyc, 2);
    chk("t3_core_ack_cyc", core_cyc, 5);

    // 4: both requesting continuously
    core_req = 1; dbg_req = 1; ng = 0; both = 0; gpat = '0;
    for (int c = 0; c < 60 && ng < 10; c++) begin
      tick();
      if (dbg_ack && core_ack) both++;
      if (dbg_ack) begin
        gpat[ng] = 1'b1;
        ng++;
      end else if (core_ack) begin
        gpat[ng] = 1'b0;
        ng++;
      end
    end
    chk("t4_grants", ng, 10);
    chk("t4_pattern", gpat, 10'b01111_01111);
    chk("t4_no_dual_ack", both, 0);
    core_req = 0; dbg_req = 0;
    tick();
    tick();

    // 5: reset during XFER of a UART read
    core_req = 1; core_wr = 0; core_addr = 14'h0010; mem_rdata = 16'h0041;
    tick();
    chk("t5_xfer", mem_rd, 1);
    rst = 1;
    tick();
    chk("t5_rst_strobes", {mem_rd, mem_wr}, 0);
    chk("t5_rst_acks", {core_ack, dbg_ack}, 0);
    chk("t5_rst_idle", busy, 0);
    rst = 0; core_req = 0; nacks = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (core_ack || dbg_ack || mem_rd) nacks++;
    end
    chk("t5_no_late_ack", nacks, 0);

    // 6: locked debug vs. starvation protection
    core_req = 1; dbg_req = 1; ndbg = 0; ncore = 0; ordinal = 0; first_core = 0;
`ifdef MMIO_ARB_LOCK_EN
    dbg_lock = 1;
`endif
    for (int c = 0; c < 80 && ndbg < 10; c++) begin
      tick();
      if (dbg_ack) begin
        ordinal++;
        ndbg++;
      end else if (core_ack) begin
        ordinal++;
        ncore++;
        if (first_core == 0) first_core = ordinal;
      end
    end
    chk("t6_dbg_grants", ndbg, 10);
`ifdef MMIO_ARB_LOCK_EN
    chk("t6_lock_core_grants", ncore, 0);
`else
    chk("t6_first_core_grant", first_core, 5);
`endif
    core_req = 0; dbg_req = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
